popcount_frame_accumulator: RTL

Downstream stage of the bit population counter. Sums the per-word popcounts of a framed stream (SOP/EOP marked) into one total per frame and also counts the frame's words. Presents each result on a valid/ready output held in a one-deep result register. The input side cannot be stalled, so frame errors and result overruns are flagged rather than back-pressured.

---
 rtl/popcount_pkg.sv | 25 ++
 rtl/popcount_frame_accumulator.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/popcount_pkg.sv
// popcount_pkg
// Shared definitions for the popcount frame accumulator.
//   acc_state_t   : accumulator FSM states (IDLE, ACCUM, DROP)
//   sum_width()   : frame sum width for a given count width and frame length
//   wcnt_width()  : word-count width able to hold 1..max_words
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DROP  = 2'd2
    } acc_state_t;

    // A frame of max_words beats, each at most 2**cnt_w - 1, fits in
    // cnt_w + log2(max_words) bits, so the sum can never wrap.
    function automatic int sum_width(input int cnt_w, input int max_words);
        return cnt_w + $clog2(max_words);
    endfunction

    // One extra bit so that max_words itself is representable.
    function automatic int wcnt_width(input int max_words);
        return $clog2(max_words) + 1;
    endfunction

endpackage

// File: rtl/popcount_frame_accumulator.sv
// popcount_frame_accumulator
// Sums per-word popcounts of a SOP/EOP framed stream into one total per
// frame and counts the beats. Results are offered through a one-deep
// valid/ready result register. The input cannot be stalled, so framing
// violations and lost results are reported as one-cycle pulses.
//
// Ports:
//   clk_i        : clock, rising edge
//   arst_ni      : asynchronous active-low reset
//   cnt_i        : popcount of the current word
//   cnt_val_i    : cnt_i valid (no back-pressure)
//   cnt_sop_i    : first beat of a frame (qualified by cnt_val_i)
//   cnt_eop_i    : last beat of a frame (qualified by cnt_val_i)
//   sum_o        : total set bits of the frame
//   words_o      : number of beats of the frame
//   sum_val_o    : result valid
//   sum_ready_i  : consumer accepts the result
//   frame_err_o  : pulse on a framing violation
//   overrun_o    : pulse when a completed frame is lost (result reg full)
//
// MAX_WORDS must be a power of two and at least 2.
module popcount_frame_accumulator
    import popcount_pkg::*;
#(
    parameter int CNT_WIDTH  = 5,
    parameter int MAX_WORDS  = 64,
    parameter int SUM_WIDTH  = sum_width(CNT_WIDTH, MAX_WORDS),
    parameter int WCNT_WIDTH = wcnt_width(MAX_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic [CNT_WIDTH-1:0]  cnt_i,
    input  logic                  cnt_val_i,
    input  logic                  cnt_sop_i,
    input  logic                  cnt_eop_i,
    output logic [SUM_WIDTH-1:0]  sum_o,
    output logic [WCNT_WIDTH-1:0] words_o,
    output logic                  sum_val_o,
    input  logic                  sum_ready_i,
    output logic                  frame_err_o,
    output logic                  overrun_o
);

    localparam logic [WCNT_WIDTH-1:0] MAX_WORDS_W = WCNT_WIDTH'(MAX_WORDS);

    acc_state_t            state;
    acc_state_t            next_state;
    logic [SUM_WIDTH-1:0]  acc_sum;
    logic [WCNT_WIDTH-1:0] acc_words;
    logic [WCNT_WIDTH-1:0] words_inc;
    logic [SUM_WIDTH-1:0]  cnt_ext;

    logic                  beat_sop;
    logic                  beat_cont;
    logic                  complete;
    logic                  err_set;
    logic                  hits_max;
    logic [SUM_WIDTH-1:0]  new_sum;
    logic [WCNT_WIDTH-1:0] new_words;
    logic                  res_load;
    logic                  res_take;

    assign cnt_ext   = SUM_WIDTH'(cnt_i);
    assign words_inc = acc_words + 1'b1;

    // State register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A sop beat restarts a frame from any state; a
    // single-word frame (sop and eop together) never leaves IDLE.
    always_comb begin
        next_state = state;
        if (cnt_val_i) begin
            if (cnt_sop_i) begin
                next_state = cnt_eop_i ? IDLE : ACCUM;
            end else begin
                unique case (state)
                    IDLE: next_state = IDLE;
                    ACCUM: begin
                        if (cnt_eop_i) begin
                            next_state = IDLE;
                        end else if (words_inc == MAX_WORDS_W) begin
                            next_state = DROP;
                        end
                    end
                    DROP: begin
                        if (cnt_eop_i) begin
                            next_state = IDLE;
                        end
                    end
                    default: next_state = IDLE;
                endcase
            end
        end
    end

    // Output/datapath decode: which beat starts, continues or completes a
    // frame, and whether it is a framing violation. The completed totals
    // always include the current beat.
    always_comb begin
        beat_sop  = cnt_val_i && cnt_sop_i;
        beat_cont = cnt_val_i && !cnt_sop_i && (state == ACCUM);
        hits_max  = beat_cont && !cnt_eop_i && (words_inc == MAX_WORDS_W);
        complete  = cnt_val_i && cnt_eop_i && (cnt_sop_i || (state == ACCUM));
        err_set   = (cnt_val_i && !cnt_sop_i && (state == IDLE))
                  || (beat_sop && (state == ACCUM))
                  || hits_max;
        if (cnt_sop_i) begin
            new_sum   = cnt_ext;
            new_words = WCNT_WIDTH'(1);
        end else begin
            new_sum   = acc_sum + cnt_ext;
            new_words = words_inc;
        end
    end

    // Working accumulators track the frame in progress.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            acc_sum   <= '0;
            acc_words <= '0;
        end else if (beat_sop || beat_cont) begin
            acc_sum   <= new_sum;
            acc_words <= new_words;
        end
    end

    // The result register may be refilled in the same cycle the old value
    // is taken, which keeps sum_val_o high without a bubble.
    assign res_take = sum_val_o && sum_ready_i;
    assign res_load = complete && (!sum_val_o || sum_ready_i);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sum_o       <= '0;
            words_o     <= '0;
            sum_val_o   <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (res_load) begin
                sum_o     <= new_sum;
                words_o   <= new_words;
                sum_val_o <= 1'b1;
            end else if (res_take) begin
                sum_val_o <= 1'b0;
            end
            frame_err_o <= err_set;
            overrun_o   <= complete && !res_load;
        end
    end

endmodule
